// File: rtl/line_splitter.sv
// Steers framed parser lines into the row or column FIFO, counts the words
// written to each, and flags framing and overflow errors.
module line_splitter #(
  parameter int MAX_ROWS        = 11,
  parameter int MAX_COLS        = 11,
  parameter int MAX_NUM_OPTIONS = 84,
  parameter int CNT_W           = $clog2(MAX_NUM_OPTIONS*MAX_ROWS+MAX_ROWS)+1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid_in,
  input  logic [15:0]      line_in,
  input  logic [3:0]       m,
  input  logic [3:0]       n,
  output logic             row_wr_en,
  output logic [15:0]      row_din,
  input  logic             row_full,
  output logic             col_wr_en,
  output logic [15:0]      col_din,
  input  logic             col_full,
  output logic [CNT_W-1:0] row_entries,
  output logic [CNT_W-1:0] col_entries,
  output logic             routed,
  output logic             busy,
  output logic             error
);

  localparam int LINES = MAX_ROWS + MAX_COLS;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [6:0] K_MAX = 7'(MAX_NUM_OPTIONS);

  typedef enum logic [1:0] {HEADER, OPTS, DROP, DONE} state_t;

  state_t           state_reg, state_next;
  logic [LINES-1:0] seen_reg, seen_next;
  logic [6:0]       remaining_reg, remaining_next;
  logic             dir_row_reg, dir_row_next;
  logic             row_wr_en_reg, row_wr_en_next;
  logic [15:0]      row_din_reg, row_din_next;
  logic             col_wr_en_reg, col_wr_en_next;
  logic [15:0]      col_din_reg, col_din_next;
  logic [CNT_W-1:0] row_cnt_reg, row_cnt_next;
  logic [CNT_W-1:0] col_cnt_reg, col_cnt_next;
  logic             routed_reg, routed_next;
  logic             error_reg, error_next;

  // Decoded fields of the incoming word
  logic             is_header;
  logic [6:0]       hdr_k;
  logic [4:0]       hdr_idx;
  logic [4:0]       total_lines;
  logic [31:0]      seen_wide;
  logic [LINES-1:0] line_mask;
  logic [LINES-1:0] hdr_onehot;
  logic             all_seen;
  logic             hdr_bad;
  logic             hdr_is_row;

  // Write request from the FSM, resolved against the FIFO full flags below
  logic             wr_req;
  logic             wr_to_row;

  assign is_header   = line_in[15];
  assign hdr_k       = line_in[14:8];
  assign hdr_idx     = line_in[4:0];
  assign total_lines = {1'b0, m} + {1'b0, n};
  assign seen_wide   = 32'(seen_reg);
  assign hdr_is_row  = hdr_idx < {1'b0, m};

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      localparam logic [4:0] IDX = 5'(gi);
      assign line_mask[gi]  = IDX < total_lines;
      assign hdr_onehot[gi] = hdr_idx == IDX;
    end
  endgenerate

  assign all_seen = (seen_reg & line_mask) == line_mask;

  assign hdr_bad = (hdr_idx >= total_lines) ||
                   (32'(hdr_idx) >= 32'(LINES)) ||
                   seen_wide[hdr_idx] ||
                   (hdr_k == 7'd0) ||
                   (hdr_k > K_MAX);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= HEADER;
      seen_reg      <= '0;
      remaining_reg <= '0;
      dir_row_reg   <= 1'b0;
      row_wr_en_reg <= 1'b0;
      row_din_reg   <= '0;
      col_wr_en_reg <= 1'b0;
      col_din_reg   <= '0;
      row_cnt_reg   <= '0;
      col_cnt_reg   <= '0;
      routed_reg    <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      seen_reg      <= seen_next;
      remaining_reg <= remaining_next;
      dir_row_reg   <= dir_row_next;
      row_wr_en_reg <= row_wr_en_next;
      row_din_reg   <= row_din_next;
      col_wr_en_reg <= col_wr_en_next;
      col_din_reg   <= col_din_next;
      row_cnt_reg   <= row_cnt_next;
      col_cnt_reg   <= col_cnt_next;
      routed_reg    <= routed_next;
      error_reg     <= error_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    seen_next      = seen_reg;
    remaining_next = remaining_reg;
    dir_row_next   = dir_row_reg;
    row_wr_en_next = 1'b0;
    row_din_next   = row_din_reg;
    col_wr_en_next = 1'b0;
    col_din_next   = col_din_reg;
    row_cnt_next   = row_cnt_reg;
    col_cnt_next   = col_cnt_reg;
    routed_next    = 1'b0;
    error_next     = error_reg;
    wr_req         = 1'b0;
    wr_to_row      = dir_row_reg;

    if (clear) begin
      state_next     = HEADER;
      seen_next      = '0;
      remaining_next = '0;
      row_cnt_next   = '0;
      col_cnt_next   = '0;
      error_next     = 1'b0;
    end else begin
      case (state_reg)
        HEADER: begin
          if (all_seen) begin
            state_next  = DONE;
            routed_next = 1'b1;
            if (valid_in) error_next = 1'b1;
          end else if (valid_in) begin
            if (!is_header) begin
              error_next = 1'b1;
            end else if (hdr_bad) begin
              // Swallow the bad group's options so framing stays aligned
              error_next     = 1'b1;
              remaining_next = hdr_k;
              if (hdr_k != 7'd0) state_next = DROP;
            end else begin
              dir_row_next   = hdr_is_row;
              wr_to_row      = hdr_is_row;
              wr_req         = 1'b1;
              seen_next      = seen_reg | hdr_onehot;
              remaining_next = hdr_k;
              state_next     = OPTS;
            end
          end
        end
        OPTS, DROP: begin
          if (valid_in) begin
            if (is_header) begin
              error_next = 1'b1;
            end else begin
              remaining_next = remaining_reg - 7'd1;
              wr_req         = (state_reg == OPTS);
              if (remaining_reg == 7'd1) state_next = HEADER;
            end
          end
        end
        DONE: begin
          if (valid_in) error_next = 1'b1;
        end
        default: state_next = HEADER;
      endcase

      // A full target FIFO loses the word but the group still advances
      if (wr_req) begin
        if (wr_to_row) begin
          if (row_full) begin
            error_next = 1'b1;
          end else begin
            row_wr_en_next = 1'b1;
            row_din_next   = line_in;
            row_cnt_next   = sat_inc(row_cnt_reg);
          end
        end else begin
          if (col_full) begin
            error_next = 1'b1;
          end else begin
            col_wr_en_next = 1'b1;
            col_din_next   = line_in;
            col_cnt_next   = sat_inc(col_cnt_reg);
          end
        end
      end
    end
  end

  assign row_wr_en   = row_wr_en_reg;
  assign row_din     = row_din_reg;
  assign col_wr_en   = col_wr_en_reg;
  assign col_din     = col_din_reg;
  assign row_entries = row_cnt_reg;
  assign col_entries = col_cnt_reg;
  assign routed      = routed_reg;
  assign busy        = (state_reg != DONE);
  assign error       = error_reg;

endmodule

// File: doc/line_splitter.md
Name: line_splitter

Overview:
- Sits between `parser` and the two line FIFOs (`fifo_r`, `fifo_c`) of the parallel solver.
- Takes the parser's single 16-bit line stream, checks its framing, and steers each line group into the row FIFO or the column FIFO.
- Counts the entries written to each FIFO so the solver knows each FIFO's initial occupancy.
- Flags protocol and overflow errors.

Parameters:
- MAX_ROWS, 11, maximum board rows.
- MAX_COLS, 11, maximum board columns.
- MAX_NUM_OPTIONS, 84, maximum options per line.
- CNT_W, $clog2(MAX_NUM_OPTIONS*MAX_ROWS+MAX_ROWS)+1 = 11, width of the entry counters.

Ports:
- clk  in  1  system clock (50 MHz domain).
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  pulse; re-arms the block for a new board.
- valid_in  in  1  `line_in` is valid this cycle.
- line_in  in  16  header or option word.
- m  in  4  number of rows; stable while busy.
- n  in  4  number of columns; stable while busy.
- row_wr_en  out  1  row FIFO write strobe.
- row_din  out  16  row FIFO data.
- row_full  in  1  row FIFO full.
- col_wr_en  out  1  column FIFO write strobe.
- col_din  out  16  column FIFO data.
- col_full  in  1  column FIFO full.
- row_entries  out  CNT_W  words written to the row FIFO.
- col_entries  out  CNT_W  words written to the column FIFO.
- routed  out  1  one-cycle pulse: all m+n lines have been routed.
- busy  out  1  state is not DONE.
- error  out  1  sticky protocol/overflow error.

Behaviour:
- Word format:
  - Header: bit15=1, [14:8]=option count k, [7:5]=0, [4:0]=line index.
  - Option: bit15=0, [10:0]=cell mask.
  - Line index 0..m-1 is a row; index m..m+n-1 is a column.
- Reset (rst_n=0 at a clock edge), which also aborts any mid-group operation with no partial state retained:
  - State goes to HEADER.
  - row_wr_en=0, col_wr_en=0, row_din=0, col_din=0.
  - row_entries=0, col_entries=0.
  - routed=0, error=0.
  - seen mask=0, remaining-option counter=0.
- All outputs are registered. A word accepted at edge t appears on *_wr_en/*_din in the cycle after edge t (latency 1). At most one FIFO is written per cycle.
- HEADER state, on valid_in:
  - Bit15=0: error<=1, word dropped, stay in HEADER.
  - Index >= m+n, or index already set in the seen mask, or k=0, or k>MAX_NUM_OPTIONS:
    - error<=1 and header dropped.
    - If k>0, go to DROP with remaining<=k; otherwise stay in HEADER.
  - Otherwise: latch dir (row if index<m), write the header to that FIFO, set the seen bit, remaining<=k, go to OPTS.
- OPTS state, on valid_in:
  - Bit15=1: error<=1, word dropped, remaining unchanged.
  - Bit15=0: write the word to the latched FIFO and decrement remaining.
  - When remaining reaches 0, return to HEADER.
- DROP state: consumes option words without writing; decrements remaining; returns to HEADER at 0.
- Completion: when back in HEADER, if seen[m+n-1:0] is all ones, go to DONE and pulse routed for exactly one cycle (the cycle after the last option write).
- DONE state:
  - busy=0; any valid_in sets error and is ignored.
  - clear resets counters, seen mask and error, and returns to HEADER.
  - clear in any other state has the same effect and aborts the current group.
- Overflow: valid_in targeting a FIFO whose *_full is high drops the word and sets error. The counter does not increment. remaining still decrements, so framing stays aligned.
- Counters: increment by 1 on each asserted write strobe and saturate at 2^CNT_W-1. Header words are included in the count.
- Simultaneous clear and valid_in: clear wins and the word is ignored.
- No valid_in: state and outputs hold; wr_en strobes deassert.

Test Plan:
- m=n=2; send headers and options for lines 0..3 (k=2,1,1,3) -> row_entries=5, col_entries=6; words appear on the FIFO ports in order, 1 cycle late; routed pulses once; error=0.
- Mid-board, header 0x8105 (index 5) with m=n=2, followed by 1 option -> both words dropped, error=1, no writes, routing continues normally.
- Option word sent while in HEADER -> dropped, error=1, counters unchanged.
- Duplicate header for index 1 after line 1 is complete, k=2 -> header and 2 options dropped (DROP state), error=1.
- row_full=1 during the 2nd option of line 0 -> that word is not written, row_entries=2 (not 3), error=1, next header routed correctly.
- rst_n=0 during OPTS; after release send a complete board -> counts start from 0 and routed pulses; clear after DONE returns busy=1 with counters at 0.
